// File: rtl/ratio_clk_pkg.sv
// Shared constants for the ratio-driven clock divider.
package ratio_clk_pkg;

  // Default width of the ratio word and of the half-period counter.
  localparam int RATIO_GRADE_DEFAULT = 5;

  // Flop depth of the enable synchronizer used when en_i is asynchronous.
  localparam int SYNC_STAGES = 2;

endpackage : ratio_clk_pkg

// File: rtl/ratio_clk_sync.sv
// N-flop single-bit synchronizer with asynchronous active-high reset.
// Brings a control bit from a foreign domain into clk_i. The output is 0
// during reset and for STAGES edges after release.
module ratio_clk_sync #(
  parameter int STAGES = 2
) (
  input  logic clk_i,
  input  logic arst_i,
  input  logic d_i,
  output logic q_o
);

  logic [STAGES-1:0] sync_q;

  // Shift the input through the flop chain; the oldest sample is the output.
  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d_i};
    end
  end

  assign q_o = sync_q[STAGES-1];

endmodule : ratio_clk_sync

// File: rtl/ratio_clock.sv
// Ratio-driven clock divider.
// Produces a 50% duty clock with a half-period of (ratio_q + 1) source cycles.
// ratio_i is latched only when the output toggles, so every half-period is
// complete and uses one ratio value. That makes run-time ratio changes
// glitch-free.
// Build option RATIO_CLK_EN_SYNC_EN: when defined, en_i passes through a
// two-flop synchronizer before use. This adds 2 cycles of enable and disable
// latency. When undefined, en_i must be synchronous to clk_i.
module ratio_clock
  import ratio_clk_pkg::*;
#(
  parameter int RATIO_GRADE = RATIO_GRADE_DEFAULT
) (
  input  logic                   clk_i,
  input  logic                   arst_i,
  input  logic                   en_i,
  input  logic [RATIO_GRADE-1:0] ratio_i,
  output logic                   ratio_clk_o
);

  logic                   en_eff;
  logic [RATIO_GRADE-1:0] cnt;
  logic [RATIO_GRADE-1:0] cnt_d;
  logic [RATIO_GRADE-1:0] ratio_q;
  logic [RATIO_GRADE-1:0] ratio_d;
  logic                   clk_q;
  logic                   clk_d;

`ifdef RATIO_CLK_EN_SYNC_EN
  // en_i comes from another domain: resynchronize it before it gates the counter.
  ratio_clk_sync #(
    .STAGES (SYNC_STAGES)
  ) u_en_sync (
    .clk_i  (clk_i),
    .arst_i (arst_i),
    .d_i    (en_i),
    .q_o    (en_eff)
  );
`else
  assign en_eff = en_i;
`endif

  // Next-state logic: count out the half-period, then toggle and latch the new ratio.
  always_comb begin
    // NOTE: every output gets a default first, so no path through the block can infer a latch.
    cnt_d   = cnt;
    ratio_d = ratio_q;
    clk_d   = clk_q;
    if (!en_eff) begin
      // Idle: the output is held low and the counter is cleared. The ratio
      // tracks the input, so the first high phase after enable uses the
      // current ratio.
      cnt_d   = '0;
      clk_d   = 1'b0;
      ratio_d = ratio_i;
    end else if (cnt == ratio_q) begin
      // Half-period boundary: this is the only point where ratio_i is sampled.
      cnt_d   = '0;
      clk_d   = ~clk_q;
      ratio_d = ratio_i;
    end else begin
      // cnt stops at ratio_q, so it never wraps, even at the maximum ratio.
      cnt_d   = cnt + RATIO_GRADE'(1);
    end
  end

  // State register. The output comes straight from clk_q, so ratio_clk_o has no combinational glitches.
  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      cnt     <= '0;
      ratio_q <= '0;
      clk_q   <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments, so all flops update together.
      cnt     <= cnt_d;
      ratio_q <= ratio_d;
      clk_q   <= clk_d;
    end
  end

  assign ratio_clk_o = clk_q;

endmodule : ratio_clock

// File: tb/tb_ratio_clock.sv
// Directed testbench for ratio_clock.
// Inputs change 1 ns after a rising edge. Outputs are sampled at the same point.
module tb_ratio_clock;

  localparam int GRADE = 5;
`ifdef RATIO_CLK_EN_SYNC_EN
  localparam int SYNC_LAT = 2;
`else
  localparam int SYNC_LAT = 0;
`endif

  logic             clk_i = 1'b0;
  logic             arst_i;
  logic             en_i;
  logic [GRADE-1:0] ratio_i;
  logic             ratio_clk_o;

  int n_tests = 0;
  int n_fail  = 0;

  ratio_clock #(
    .RATIO_GRADE (GRADE)
  ) dut (
    .clk_i       (clk_i),
    .arst_i      (arst_i),
    .en_i        (en_i),
    .ratio_i     (ratio_i),
    .ratio_clk_o (ratio_clk_o)
  );

  always #5 clk_i = ~clk_i;

  // Advance one source cycle and land 1 ns after the rising edge.
  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  // Count the edges until the output reaches lvl. Returns -1 if the budget runs out.
  task automatic count_until(input logic lvl, input int budget, output int n);
    n = 0;
    while (ratio_clk_o !== lvl && n < budget) begin
      step();
      n++;
    end
    if (ratio_clk_o !== lvl) n = -1;
  endtask

  // Drop enable long enough to reach idle, load a ratio, then re-enable.
  task automatic restart(input logic [GRADE-1:0] r);
    en_i    = 1'b0;
    ratio_i = r;
    repeat (SYNC_LAT + 2) step();
    en_i = 1'b1;
  endtask

  task automatic test_reset();
    int n;
    int exp_first;
    arst_i  = 1'b1;
    en_i    = 1'b1;
    ratio_i = 5'd3;
    for (int i = 0; i < 4; i++) begin
      step();
      n_tests++;
      if (ratio_clk_o !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_hold cyc=%0d got=%b exp=0", i, ratio_clk_o);
      end
    end
    arst_i = 1'b0;
    // Without the synchronizer, ratio_q is still 0 from reset, so the first
    // toggle comes at the first edge. With the synchronizer, the two idle
    // edges load ratio 3 first.
    exp_first = (SYNC_LAT != 0) ? (4 + SYNC_LAT) : 1;
    count_until(1'b1, 32, n);
    n_tests++;
    if (n !== exp_first) begin
      n_fail++;
      $display("FAIL reset_first_rise got=%0d exp=%0d", n, exp_first);
    end
    count_until(1'b0, 32, n);
    n_tests++;
    if (n !== 4) begin
      n_fail++;
      $display("FAIL reset_high_phase got=%0d exp=4", n);
    end
    count_until(1'b1, 32, n);
    n_tests++;
    if (n !== 4) begin
      n_fail++;
      $display("FAIL reset_low_phase got=%0d exp=4", n);
    end
  endtask

  task automatic test_ratio0();
    int n;
    logic prev;
    restart(5'd0);
    count_until(1'b1, 32, n);
    n_tests++;
    if (n !== 1 + SYNC_LAT) begin
      n_fail++;
      $display("FAIL ratio0_first_rise got=%0d exp=%0d", n, 1 + SYNC_LAT);
    end
    for (int i = 0; i < 100; i++) begin
      prev = ratio_clk_o;
      step();
      n_tests++;
      if (ratio_clk_o !== ~prev) begin
        n_fail++;
        $display("FAIL ratio0_toggle cyc=%0d got=%b exp=%b", i, ratio_clk_o, ~prev);
      end
    end
  endtask

  task automatic test_sweep();
    int   n;
    int   cur;
    int   drv;
    int   rises;
    int   bumps;
    logic lvl;
    restart(5'd0);
    drv = 0;
    count_until(1'b1, 64, n);
    n_tests++;
    if (n !== 1 + SYNC_LAT) begin
      n_fail++;
      $display("FAIL sweep_first_rise got=%0d exp=%0d", n, 1 + SYNC_LAT);
    end
    cur   = drv;
    rises = 1;
    bumps = 0;
    while (bumps < 33) begin
      lvl = ~ratio_clk_o;
      count_until(lvl, 64, n);
      n_tests++;
      if (n !== cur + 1) begin
        n_fail++;
        $display("FAIL sweep_half_period ratio=%0d lvl=%b got=%0d exp=%0d", cur, lvl, n, cur + 1);
        if (n < 0) break;
      end
      // The toggle edge latched whatever ratio_i held at that edge.
      cur = drv;
      if (lvl == 1'b1) begin
        rises++;
        if (rises % 4 == 0) begin
          drv     = (drv + 1) % 32;
          ratio_i = drv[GRADE-1:0];
          bumps++;
        end
      end
    end
  endtask

  task automatic test_ratio_change();
    int n;
    restart(5'd7);
    count_until(1'b1, 64, n);
    n_tests++;
    if (n !== 8 + SYNC_LAT) begin
      n_fail++;
      $display("FAIL change_first_rise got=%0d exp=%0d", n, 8 + SYNC_LAT);
    end
    repeat (3) step();
    ratio_i = 5'd1;
    count_until(1'b0, 64, n);
    n_tests++;
    if (n !== 5) begin
      n_fail++;
      $display("FAIL change_high_rest got=%0d exp=5 (8 total)", n);
    end
    count_until(1'b1, 64, n);
    n_tests++;
    if (n !== 2) begin
      n_fail++;
      $display("FAIL change_low_phase got=%0d exp=2", n);
    end
    count_until(1'b0, 64, n);
    n_tests++;
    if (n !== 2) begin
      n_fail++;
      $display("FAIL change_high_phase got=%0d exp=2", n);
    end
  endtask

  task automatic test_disable();
    int n;
    restart(5'd5);
    count_until(1'b1, 64, n);
    n_tests++;
    if (n !== 6 + SYNC_LAT) begin
      n_fail++;
      $display("FAIL dis_first_rise got=%0d exp=%0d", n, 6 + SYNC_LAT);
    end
    repeat (2) step();
    en_i = 1'b0;
    for (int i = 0; i < SYNC_LAT; i++) begin
      step();
      n_tests++;
      if (ratio_clk_o !== 1'b1) begin
        n_fail++;
        $display("FAIL dis_latency cyc=%0d got=%b exp=1", i, ratio_clk_o);
      end
    end
    step();
    n_tests++;
    if (ratio_clk_o !== 1'b0) begin
      n_fail++;
      $display("FAIL dis_drop got=%b exp=0", ratio_clk_o);
    end
    for (int i = 0; i < 4; i++) begin
      step();
      n_tests++;
      if (ratio_clk_o !== 1'b0) begin
        n_fail++;
        $display("FAIL dis_hold cyc=%0d got=%b exp=0", i, ratio_clk_o);
      end
    end
    en_i = 1'b1;
    count_until(1'b1, 64, n);
    n_tests++;
    if (n !== 6 + SYNC_LAT) begin
      n_fail++;
      $display("FAIL reen_first_rise got=%0d exp=%0d", n, 6 + SYNC_LAT);
    end
  endtask

  task automatic test_async_reset();
    int n;
    restart(5'd5);
    count_until(1'b1, 64, n);
    n_tests++;
    if (n !== 6 + SYNC_LAT) begin
      n_fail++;
      $display("FAIL arst_first_rise got=%0d exp=%0d", n, 6 + SYNC_LAT);
    end
    repeat (2) step();
    #2;
    arst_i = 1'b1;
    #1;
    n_tests++;
    if (ratio_clk_o !== 1'b0) begin
      n_fail++;
      $display("FAIL arst_out got=%b exp=0", ratio_clk_o);
    end
    n_tests++;
    if (dut.cnt !== 5'd0) begin
      n_fail++;
      $display("FAIL arst_cnt got=%0d exp=0", dut.cnt);
    end
    n_tests++;
    if (dut.ratio_q !== 5'd0) begin
      n_fail++;
      $display("FAIL arst_ratio_q got=%0d exp=0", dut.ratio_q);
    end
    step();
    arst_i = 1'b0;
  endtask

  initial begin
    arst_i  = 1'b1;
    en_i    = 1'b0;
    ratio_i = '0;
    test_reset();
    test_ratio0();
    test_sweep();
    test_ratio_change();
    test_disable();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Absolute time limit so the run always ends.
  initial begin
    #2_000_000;
    $display("FAIL timeout sim_time=%0t exp=finished", $time);
    $fatal(1, "time limit");
  end

endmodule : tb_ratio_clock
